bcd_scan_counter: RTL

//  Two-digit (00-99) BCD up/down counter with built-in prescaler and display

---
 rtl/bcd_scan_counter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: two-digit (00-99) BCD up/down counter with a tick
// prescaler and a two-digit display scanner. It feeds a single BCD-to-7-segment
// decoder that is time-multiplexed across both LED digits.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   en       in   1  count enable; 0 freezes prescaler and count
//   up       in   1  direction, 1 = increment, 0 = decrement (sampled on tick)
//   clr      in   1  synchronous clear of count and prescaler
//   ones     out  4  units digit, BCD 0-9 (registered)
//   tens     out  4  tens digit, BCD 0-9 (registered)
//   carry    out  1  one-cycle pulse after a wrap, 99->00 or 00->99 (registered)
//   bcd_out  out  4  digit currently scanned (decoded from registered state)
//   dig_sel  out  2  active-low digit enables: [0] = ones LED, [1] = tens LED
module bcd_scan_counter #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned SCAN_DIV = 50_000,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry,
    output logic [3:0] bcd_out,
    output logic [1:0] dig_sel
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic {
        SCAN_ONES = 1'b0,
        SCAN_TENS = 1'b1
    } scan_state_e;

    logic [TW-1:0] presc_q, presc_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic          carry_q, carry_d;
    logic          tick_c;

    logic [SW-1:0] scan_cnt_q;
    scan_state_e   scan_q;

    // One count step per TICK_DIV enabled clocks.
    assign tick_c = en && (presc_q == TICK_LAST);

    // Next count: clear wins over a coincident tick; BCD digits roll over in
    // both directions and a full wrap raises carry for one cycle.
    always_comb begin
        presc_d = presc_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        carry_d = 1'b0;
        if (clr) begin
            presc_d = '0;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
        end else begin
            if (en) begin
                presc_d = tick_c ? '0 : presc_q + TW'(1);
            end
            if (tick_c) begin
                if (up) begin
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        if (tens_q == 4'd9) begin
                            tens_d  = 4'd0;
                            carry_d = 1'b1;
                        end else begin
                            tens_d = tens_q + 4'd1;
                        end
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end else begin
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        if (tens_q == 4'd0) begin
                            tens_d  = 4'd9;
                            carry_d = 1'b1;
                        end else begin
                            tens_d = tens_q - 4'd1;
                        end
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
        end
    end

    // Count and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            carry_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            carry_q <= carry_d;
        end
    end

    // Free-running scanner: alternate digits every SCAN_DIV clocks,
    // unaffected by en and clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            scan_q     <= SCAN_ONES;
        end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            scan_q     <= (scan_q == SCAN_ONES) ? SCAN_TENS : SCAN_ONES;
        end else begin
            scan_cnt_q <= scan_cnt_q + SW'(1);
        end
    end

    // Display mux decoded from registered state so a count change shows on
    // bcd_out in the same cycle as on ones/tens. Only one enable is ever low.
    always_comb begin
        bcd_out = ones_q;
        dig_sel = 2'b10;
        if (scan_q == SCAN_TENS) begin
            bcd_out = tens_q;
            dig_sel = (BLANK_LZ && (tens_q == 4'd0)) ? 2'b11 : 2'b01;
        end
    end

    assign ones  = ones_q;
    assign tens  = tens_q;
    assign carry = carry_q;

endmodule
